// File: rtl/soric_pkg.sv
// Shared constants for the SoRIC memory datapath: bus widths, requester indices
// and the arbiter state encoding.
package soric_pkg;

    localparam int MEM_BE_W = 4;
    localparam int MEM_DW   = 32;

    localparam int REQ_CORE = 0;
    localparam int REQ_UART = 1;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_STALL = 2'd2;

endpackage

// File: rtl/mem_id_fifo.sv
// Synchronous FIFO of requester indices for accepted memory transactions.
// A push and a pop may happen in the same cycle even when the FIFO is full.
module mem_id_fifo
    import soric_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push lands in, so full does not block it
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between requesters,
// with grant locking and in-order response routing through an ID FIFO.
module mem_port_arbiter
    import soric_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_OUTST  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*MEM_BE_W-1:0]    be_i,
    input  logic [NUM_REQ*MEM_DW-1:0]      wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [MEM_DW-1:0]              rdata_o,
    output logic                           mem_req_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic                           mem_we_o,
    output logic [MEM_BE_W-1:0]            mem_be_o,
    output logic [MEM_DW-1:0]              mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [MEM_DW-1:0]              mem_rdata_i,
    output logic                           err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [IDX_W-1:0] rr_ptr_q;
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             err_q;

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [1:0]       state;
    logic             can_issue;
    logic             accept;
    logic             spurious;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [IDX_W-1:0] fifo_head;
    logic             fifo_pop;

    // First requester at or above rr_ptr, wrapping around
    always_comb begin
        scan_idx = rr_ptr_q;
        cand     = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                scan_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign winner    = lock_q ? lock_idx_q : scan_idx;
    assign can_issue = ~fifo_full | mem_rvalid_i;

    always_comb begin
        state = ARB_IDLE;
        if (req_i[winner]) begin
            state = can_issue ? ARB_ISSUE : ARB_STALL;
        end
    end

    assign mem_req_o   = rst_ni & (state == ARB_ISSUE);
    assign mem_addr_o  = addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_we_o    = we_i[winner];
    assign mem_be_o    = be_i[winner*MEM_BE_W +: MEM_BE_W];
    assign mem_wdata_o = wdata_i[winner*MEM_DW +: MEM_DW];

    assign accept   = mem_req_o & mem_gnt_i;
    assign fifo_pop = rst_ni & mem_rvalid_i & ~fifo_empty;
    assign spurious = mem_rvalid_i & (fifo_count == '0);

    always_comb begin
        gnt_o = '0;
        if (accept) begin
            gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (fifo_pop) begin
            rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata_i;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_q <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                lock_q   <= 1'b0;
            end else if (mem_req_o) begin
                // Hold the winner while memory back-pressures, so no preemption
                lock_q     <= 1'b1;
                lock_idx_q <= winner;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    mem_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
